// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Byte-side and line-side signal bundle for the UART receiver.
//            The master modport belongs to the receiver and the slave modport
//            to whatever drives the line and consumes the bytes.
// Signals  : rx           serial line, idles high
//            rx_ready     consumer accepts the byte when rx_valid && rx_ready
//            rx_data      received byte, stable while rx_valid is high
//            rx_valid     byte available, held until accepted
//            rx_frame_err one-cycle pulse, stop bit sampled low
//            rx_overrun   one-cycle pulse, byte dropped because the previous
//                         byte was still unaccepted
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;

    modport master (
        input  rx,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_overrun
    );

    modport slave (
        output rx,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  rx_frame_err,
        input  rx_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. Bit timing comes from an internal cycle
//            counter on the single system clock. Received bytes are offered
//            on a valid/ready interface; framing errors and overruns are
//            reported as one-cycle pulses.
// Ports    : clk  system clock, all logic on posedge
//            rst  synchronous active-high reset
//            bus  uart_rx_if.master (rx, rx_ready in; rx_data, rx_valid,
//                 rx_frame_err, rx_overrun out)
// Params   : CLKS_PER_BIT  clk cycles per bit (>= 4)
//            MSB_FIRST     0: data bit 0 first on the line, 1: bit 7 first
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  wire logic  clk,
    input  wire logic  rst,
    uart_rx_if.master  bus
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_HALF  = CLKS_PER_BIT / 2;

    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    // Line synchronizer and edge detect
    logic       r_sync1;
    logic       r_rx_s;
    logic       r_rx_prev;
    logic [1:0] r_sync_vld;
    logic       w_start;

    // FSM and datapath
    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]           r_bit_idx, w_bit_idx_nxt;
    logic [7:0]           r_shreg, w_shreg_nxt;
    logic                 w_deliver;
    logic                 w_frame_err;

    // Byte-side outputs
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_frame_err;
    logic       r_overrun;

    // The synchronizer flops reset to 1, so for two cycles after reset r_rx_s
    // reflects the reset value rather than the line. r_sync_vld tracks when
    // r_rx_s carries a real sample; r_rx_prev only records a genuine high, so
    // a line held low through reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_prev  <= 1'b0;
            r_sync_vld <= 2'b00;
        end else begin
            r_sync1    <= bus.rx;
            r_rx_s     <= r_sync1;
            r_rx_prev  <= r_rx_s & r_sync_vld[1];
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    assign w_start = r_rx_prev & ~r_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shreg   <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + c_CNT_ONE;
        w_bit_idx_nxt = r_bit_idx;
        w_shreg_nxt   = r_shreg;
        w_deliver     = 1'b0;
        w_frame_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start) begin
                    w_state_nxt = S_START;
                    // The detect cycle is already the first cycle of the
                    // start bit, so counting resumes at one.
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end

            S_START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_state_nxt   = S_DATA;
                        w_bit_idx_nxt = 3'd0;
                    end else begin
                        // Line back high at mid start bit: a glitch
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (MSB_FIRST) begin
                        w_shreg_nxt = {r_shreg[6:0], r_rx_s};
                    end else begin
                        w_shreg_nxt = {r_rx_s, r_shreg[7:1]};
                    end
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end

            S_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                // A low stop bit may be the start of a break; hold off until
                // the line has recovered so the break is reported only once.
                w_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A delivery wins over an accept on the same edge: rx_valid stays high
    // and carries the new byte. A delivery into an unaccepted slot keeps the
    // old byte and reports the loss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || bus.rx_ready) begin
                    r_data  <= r_shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data      = r_data;
    assign bus.rx_valid     = r_valid;
    assign bus.rx_frame_err = r_frame_err;
    assign bus.rx_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx with a 16-cycle bit period.
//            Two receivers share the line, one LSB-first and one MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLKS = 16;

    logic clk = 1'b0;
    logic rst;

    uart_rx_if bus0 ();
    uart_rx_if bus1 ();

    uart_rx #(.CLKS_PER_BIT(CLKS), .MSB_FIRST(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS), .MSB_FIRST(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // lb[k] is the k-th data bit on the line after the start bit
    typedef struct {
        logic [7:0] lb;
        logic       stop;
        logic       ready;
        logic       exp_pre_valid;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_ovr;
        logic       exp_next_valid;
        logic       accept_after;
        int         gap;
    } vec_t;

    vec_t tbl [6];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0b required %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %02h required %02h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input logic v);
        bus0.rx = v;
        bus1.rx = v;
    endtask

    // Starts at E+1 (just after edge E); returns at E+145 with the stop bit
    // on the line.
    task automatic drive_frame(input logic [7:0] lb, input logic stop);
        set_rx(1'b0);
        tick(CLKS);
        for (int k = 0; k < 8; k++) begin
            set_rx(lb[k]);
            tick(CLKS);
        end
        set_rx(stop);
    endtask

    // With the line going low just after edge E, the stop sample falls on
    // edge E+154, so results are checked just after it and one cycle either
    // side of it.
    task automatic run_vec(input string tag, input vec_t v);
        bus0.rx_ready = v.ready;
        drive_frame(v.lb, v.stop);
        tick(9);
        chk1({tag, "_pre_valid"}, bus0.rx_valid, v.exp_pre_valid);
        chk1({tag, "_pre_ferr"}, bus0.rx_frame_err, 1'b0);
        chk1({tag, "_pre_ovr"}, bus0.rx_overrun, 1'b0);
        tick(1);
        chk1({tag, "_valid"}, bus0.rx_valid, v.exp_valid);
        chk8({tag, "_data"}, bus0.rx_data, v.exp_data);
        chk1({tag, "_ferr"}, bus0.rx_frame_err, v.exp_ferr);
        chk1({tag, "_ovr"}, bus0.rx_overrun, v.exp_ovr);
        chk1({tag, "_msb_valid"}, bus1.rx_valid, v.stop);
        if (v.stop) begin
            chk8({tag, "_msb_data"}, bus1.rx_data, rev8(v.lb));
        end
        tick(1);
        chk1({tag, "_next_valid"}, bus0.rx_valid, v.exp_next_valid);
        chk1({tag, "_next_ferr"}, bus0.rx_frame_err, 1'b0);
        chk1({tag, "_next_ovr"}, bus0.rx_overrun, 1'b0);
        tick(5);
        set_rx(1'b1);
        if (v.accept_after) begin
            bus0.rx_ready = 1'b1;
            chk1({tag, "_acc_valid"}, bus0.rx_valid, 1'b1);
            chk8({tag, "_acc_data"}, bus0.rx_data, v.exp_data);
            tick(1);
            chk1({tag, "_acc_drop"}, bus0.rx_valid, 1'b0);
        end
        if (v.gap > 0) tick(v.gap);
    endtask

    // Counts frame-error pulses and any valid/overrun activity over n cycles
    task automatic watch(input int n, output int fe, output int act);
        fe  = 0;
        act = 0;
        repeat (n) begin
            tick(1);
            if (bus0.rx_frame_err) fe++;
            if (bus0.rx_valid || bus0.rx_overrun) act++;
        end
    endtask

    initial begin
        vec_t       v;
        int         fe;
        int         act;
        logic [7:0] part;

        //          lb     stop  rdy   pre   vld   data   ferr  ovr   next  acc   gap
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 20};
        tbl[2] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 20};
        tbl[3] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 20};
        tbl[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 20};
        tbl[5] = '{8'hC1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 20};

        rst           = 1'b1;
        bus0.rx_ready = 1'b1;
        bus1.rx_ready = 1'b1;
        set_rx(1'b1);
        tick(3);
        chk1("rst_valid", bus0.rx_valid, 1'b0);
        chk8("rst_data", bus0.rx_data, 8'h00);
        chk1("rst_ferr", bus0.rx_frame_err, 1'b0);
        chk1("rst_ovr", bus0.rx_overrun, 1'b0);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Short low glitch: rejected at the mid start-bit sample
        set_rx(1'b0);
        tick(3);
        set_rx(1'b1);
        watch(40, fe, act);
        chk_int("glitch_ferr", fe, 0);
        chk_int("glitch_act", act, 0);
        v = '{8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 20};
        run_vec("post_glitch", v);

        // Break: 40 bit times low gives exactly one framing error
        set_rx(1'b0);
        watch(40 * CLKS, fe, act);
        chk_int("break_ferr", fe, 1);
        chk_int("break_act", act, 0);
        set_rx(1'b1);
        watch(20, fe, act);
        chk_int("break_end_ferr", fe, 0);
        chk_int("break_end_act", act, 0);
        v = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 20};
        run_vec("post_break", v);

        // Leave a byte pending so reset has something visible to clear
        v = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 20};
        run_vec("pre_reset", v);

        // Partial 0x81 frame, reset taken on the data bit 4 sample (E+90)
        part = 8'h81;
        set_rx(1'b0);
        tick(CLKS);
        for (int k = 0; k < 4; k++) begin
            set_rx(part[k]);
            tick(CLKS);
        end
        set_rx(part[4]);
        tick(9);
        rst = 1'b1;
        tick(1);
        chk1("midrst_valid", bus0.rx_valid, 1'b0);
        chk8("midrst_data", bus0.rx_data, 8'h00);
        chk1("midrst_ferr", bus0.rx_frame_err, 1'b0);
        chk1("midrst_ovr", bus0.rx_overrun, 1'b0);

        // Line low through and after reset must not start a frame
        set_rx(1'b0);
        tick(4);
        rst = 1'b0;
        watch(300, fe, act);
        chk_int("lowrst_ferr", fe, 0);
        chk_int("lowrst_act", act, 0);
        set_rx(1'b1);
        tick(20);
        v = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 20};
        run_vec("post_reset", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
